// File: rtl/idct_8.sv
// Eight-point Q8 inverse DCT: even/odd multiply-accumulate over four ACC cycles, then an output butterfly.
// Define IDCT_SAT_EN to clamp results to the signed M-bit range; otherwise results wrap to M bits.
module idct_8 #(
  parameter int M = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [M*8-1:0] data,
  output logic           ready,
  output logic [M*8-1:0] out
);

  localparam int ACC_W  = M + 12;
  localparam int COEF_W = 9;

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(128);
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((2 ** (M - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(2 ** (M - 1)));

  // Rows n=0..3 only; rows 4..7 follow from C[7-n][k] = (-1)^k * C[n][k] in the butterfly.
  localparam logic signed [COEF_W-1:0] COEF [4][8] = '{
    '{9'sd181,  9'sd251,  9'sd237,  9'sd213,  9'sd181,  9'sd142,  9'sd98,   9'sd50},
    '{9'sd181,  9'sd213,  9'sd98,  -9'sd50,  -9'sd181, -9'sd251, -9'sd237, -9'sd142},
    '{9'sd181,  9'sd142, -9'sd98,  -9'sd251, -9'sd181,  9'sd50,   9'sd237,  9'sd213},
    '{9'sd181,  9'sd50,  -9'sd237, -9'sd142,  9'sd181,  9'sd213, -9'sd98,  -9'sd251}
  };

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT, S_HOLD} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              j_q, j_d;
  logic signed [M-1:0]     x_q [8];
  logic signed [M-1:0]     x_d [8];
  logic signed [ACC_W-1:0] e_q [4];
  logic signed [ACC_W-1:0] e_d [4];
  logic signed [ACC_W-1:0] o_q [4];
  logic signed [ACC_W-1:0] o_d [4];
  logic [M*8-1:0]          out_q, out_d;
  logic                    ready_q, ready_d;

  function automatic logic signed [ACC_W-1:0] mac_term(
    input logic signed [M-1:0]      x,
    input logic signed [COEF_W-1:0] c
  );
    return ACC_W'(x) * ACC_W'(c);
  endfunction

  function automatic logic signed [M-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
`ifdef IDCT_SAT_EN
    logic signed [ACC_W-1:0] r;
    r = (acc + HALF) >>> 8;
    if (r > SMAX) return {1'b0, {(M-1){1'b1}}};
    else if (r < SMIN) return {1'b1, {(M-1){1'b0}}};
    else return r[M-1:0];
`else
    return M'((acc + HALF) >>> 8);
`endif
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_ACC;
      S_ACC: begin
        if (!start)            state_d = S_IDLE;
        else if (j_q == 2'd3)  state_d = S_OUT;
      end
      S_OUT:  state_d = start ? S_HOLD : S_IDLE;
      S_HOLD: if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_d     = x_q;
    e_d     = e_q;
    o_d     = o_q;
    j_d     = j_q;
    out_d   = out_q;
    ready_d = ready_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int k = 0; k < 8; k++) x_d[k] = data[M*k +: M];
          for (int n = 0; n < 4; n++) begin
            e_d[n] = '0;
            o_d[n] = '0;
          end
          j_d = 2'd0;
        end
      end
      S_ACC: begin
        // Step j consumes the coefficient pair X[2j] (even) and X[2j+1] (odd).
        if (start) begin
          for (int n = 0; n < 4; n++) begin
            e_d[n] = e_q[n] + mac_term(x_q[{j_q, 1'b0}], COEF[n][{j_q, 1'b0}]);
            o_d[n] = o_q[n] + mac_term(x_q[{j_q, 1'b1}], COEF[n][{j_q, 1'b1}]);
          end
          j_d = j_q + 2'd1;
        end
      end
      S_OUT: begin
        if (start) begin
          for (int n = 0; n < 4; n++) begin
            out_d[M*n +: M]       = round_sat(e_q[n] + o_q[n]);
            out_d[M*(7-n) +: M]   = round_sat(e_q[n] - o_q[n]);
          end
          ready_d = 1'b1;
        end
      end
      S_HOLD: if (!start) ready_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) x_q[k] <= '0;
      for (int n = 0; n < 4; n++) begin
        e_q[n] <= '0;
        o_q[n] <= '0;
      end
      j_q     <= 2'd0;
      out_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      e_q     <= e_d;
      o_q     <= o_d;
      j_q     <= j_d;
      out_q   <= out_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;
  assign out   = out_q;

endmodule

// File: tb/tb_idct_8.sv
// Directed bench for idct_8 (M=16): known spectra with hand-computed samples, handshake abort/hold, reset.
module tb_idct_8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] data;
  logic         ready;
  logic [127:0] out;

  int n_checks = 0;
  int n_err    = 0;
  int xin   [8];
  int exp_y [8];

  idct_8 #(.M(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .data  (data),
    .ready (ready),
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pack_x();
    logic [127:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) p[16*k +: 16] = 16'(xin[k]);
    return p;
  endfunction

  task automatic check_out(input string name);
    for (int n = 0; n < 8; n++)
      check($sformatf("%s y%0d", name, n), 32'($signed(out[16*n +: 16])), 32'(exp_y[n]));
  endtask

  // Called right after an edge with start already high: next edge is the capture edge.
  task automatic run_txn(input string name, input int hold);
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) check($sformatf("%s ready@5", name), 32'(ready), 32'd0);
    end
    check($sformatf("%s ready@6", name), 32'(ready), 32'd1);
    check_out(name);
    for (int h = 0; h < hold; h++) begin
      tick();
      check($sformatf("%s hold ready %0d", name, h), 32'(ready), 32'd1);
    end
    if (hold > 0) check_out({name, " held"});
    start = 1'b0;
    tick();
    check($sformatf("%s ready fall", name), 32'(ready), 32'd0);
    check($sformatf("%s y0 kept", name), 32'($signed(out[15:0])), 32'(exp_y[0]));
  endtask

  task automatic start_txn(input string name, input int hold);
    data  = pack_x();
    start = 1'b1;
    run_txn(name, hold);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    data  = '0;
    tick();
    tick();
    check("reset ready", 32'(ready), 32'd0);
    for (int n = 0; n < 8; n++)
      check($sformatf("reset y%0d", n), 32'($signed(out[16*n +: 16])), 32'd0);
    rst = 1'b0;

    xin   = '{256, 0, 0, 0, 0, 0, 0, 0};
    exp_y = '{181, 181, 181, 181, 181, 181, 181, 181};
    start_txn("dc", 0);

    xin   = '{0, 256, 0, 0, 0, 0, 0, 0};
    exp_y = '{251, 213, 142, 50, -50, -142, -213, -251};
    start_txn("h1", 0);

    xin   = '{0, 0, 0, 0, 1, 0, 0, 0};
    exp_y = '{1, -1, -1, 1, 1, -1, -1, 1};
    start_txn("rnd", 0);

    xin   = '{32767, 0, 32767, 0, 0, 0, 0, 0};
`ifdef IDCT_SAT_EN
    exp_y = '{32767, 32767, 10624, -7168, -7168, 10624, 32767, 32767};
`else
    exp_y = '{-12034, -29825, 10624, -7168, -7168, 10624, -29825, -12034};
`endif
    start_txn("ovf", 0);

    // Abort during ACC: start sampled low on edge 3.
    xin   = '{256, 0, 0, 0, 0, 0, 0, 0};
    data  = pack_x();
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("abort ready %0d", i), 32'(ready), 32'd0);
    end
    check_out("abort kept");

    xin   = '{0, 256, 0, 0, 0, 0, 0, 0};
    exp_y = '{251, 213, 142, 50, -50, -142, -213, -251};
    start_txn("after abort", 10);

    // Asynchronous reset during ACC, start kept high through and after it.
    xin   = '{256, 0, 0, 0, 0, 0, 0, 0};
    exp_y = '{181, 181, 181, 181, 181, 181, 181, 181};
    data  = pack_x();
    start = 1'b1;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid rst ready", 32'(ready), 32'd0);
    for (int n = 0; n < 8; n++)
      check($sformatf("mid rst y%0d", n), 32'($signed(out[16*n +: 16])), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_txn("rst recover", 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
